// File: rtl/snax_mac_job_sequencer.sv
`timescale 1ns/1ps
// Job sequencer for a SNAX MAC engine: programs config registers over the peripheral
// bus, triggers the engine, times it until its event, polls status, then reports cycles.
module snax_mac_job_sequencer #(
    parameter int unsigned NumCfgRegs = 4,
    parameter int unsigned IdWidth    = 5,
    parameter logic [31:0] CfgBase    = 32'h40
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic                       job_valid_i,
    output logic                       job_ready_o,
    input  logic [32*NumCfgRegs-1:0]   job_cfg_i,

    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [31:0]                resp_cycles_o,

    output logic                       periph_req_o,
    input  logic                       periph_gnt_i,
    output logic [31:0]                periph_add_o,
    output logic                       periph_wen_o,
    output logic [3:0]                 periph_be_o,
    output logic [31:0]                periph_data_o,
    output logic [IdWidth-1:0]         periph_id_o,

    input  logic [31:0]                periph_r_data_i,
    input  logic                       periph_r_valid_i,
    input  logic [IdWidth-1:0]         periph_r_id_i,

    input  logic                       evt_i
);

    localparam int unsigned     IdxW    = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumCfgRegs - 1);

    localparam logic [31:0] TrigAddr   = 32'h00;
    localparam logic [31:0] StatusAddr = 32'h0C;

    typedef enum logic [2:0] {
        StIdle,
        StCfg,
        StTrig,
        StWaitEvt,
        StPollReq,
        StPollRsp,
        StResp
    } state_e;

    state_e                   r_state;
    state_e                   w_state_d;
    logic [32*NumCfgRegs-1:0] r_cfg;
    logic [IdxW-1:0]          r_idx;
    logic [31:0]              r_cnt;
    logic [IdWidth-1:0]       r_tag;
    logic [IdWidth-1:0]       r_rd_tag;
    logic                     w_gnt;
    logic                     w_rsp_hit;

    assign w_gnt         = periph_req_o & periph_gnt_i;
    assign w_rsp_hit     = periph_r_valid_i && (periph_r_id_i == r_rd_tag);
    assign resp_cycles_o = r_cnt;

    always_comb begin
        w_state_d     = r_state;
        job_ready_o   = 1'b0;
        resp_valid_o  = 1'b0;
        periph_req_o  = 1'b0;
        periph_wen_o  = 1'b1;
        periph_be_o   = 4'h0;
        periph_add_o  = 32'h0;
        periph_data_o = 32'h0;
        periph_id_o   = '0;
        unique case (r_state)
            StIdle: begin
                job_ready_o = 1'b1;
                if (job_valid_i) w_state_d = StCfg;
            end
            StCfg: begin
                // Fields come straight from registers, so they hold while the grant is withheld.
                periph_req_o  = 1'b1;
                periph_wen_o  = 1'b0;
                periph_be_o   = 4'hF;
                periph_add_o  = CfgBase + (32'(r_idx) << 2);
                periph_data_o = r_cfg[32*int'(r_idx) +: 32];
                periph_id_o   = r_tag;
                if (periph_gnt_i && (r_idx == LastIdx)) w_state_d = StTrig;
            end
            StTrig: begin
                periph_req_o  = 1'b1;
                periph_wen_o  = 1'b0;
                periph_be_o   = 4'hF;
                periph_add_o  = TrigAddr;
                periph_id_o   = r_tag;
                if (periph_gnt_i) w_state_d = StWaitEvt;
            end
            StWaitEvt: begin
                if (evt_i) w_state_d = StPollReq;
            end
            StPollReq: begin
                periph_req_o = 1'b1;
                periph_be_o  = 4'hF;
                periph_add_o = StatusAddr;
                periph_id_o  = r_tag;
                if (periph_gnt_i) w_state_d = StPollRsp;
            end
            StPollRsp: begin
                if (w_rsp_hit) begin
                    w_state_d = (periph_r_data_i == 32'h0) ? StResp : StPollReq;
                end
            end
            StResp: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_cfg    <= '0;
            r_idx    <= '0;
            r_cnt    <= 32'h0;
            r_tag    <= '0;
            r_rd_tag <= '0;
        end else begin
            r_state <= w_state_d;

            if (r_state == StIdle && job_valid_i) begin
                r_cfg <= job_cfg_i;
                r_idx <= '0;
            end else if (r_state == StCfg && periph_gnt_i) begin
                r_idx <= r_idx + IdxW'(1);
            end

            if (w_gnt) r_tag <= r_tag + IdWidth'(1);

            if (r_state == StPollReq && periph_gnt_i) r_rd_tag <= r_tag;

            // The event cycle itself is not counted; the count saturates rather than wraps.
            if (r_state == StTrig && periph_gnt_i) begin
                r_cnt <= 32'h0;
            end else if (r_state == StWaitEvt && !evt_i && r_cnt != 32'hFFFF_FFFF) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

endmodule
